cs2fifoc: RTL and testbench
===========================

// Module: cs2fifoc
// PURPOSE
//  Command-frame transmitter: snapshots nine command registers on start, frames them as
//  HEAD0, HEAD1, 9 payload bytes, 8-bit checksum (12 bytes) and writes them into the TX command FIFO.
//  Mirror of the command-FIFO frame decoder: same byte order, same checksum, same fs/fd handshake.
// PARAMETERS
//  HEAD0    8'h55   first header byte
//  HEAD1    8'hAA   second header byte
//  TIMEOUT  16'd1000 max consecutive full-stall cycles before err (FIFOC_FULL_WAIT_EN only)
// PORTS
//  clk        in   1  clock
//  rst        in   1  reset, asynchronous, active-high
//  fs         in   1  frame start request (level)
//  fd         out  1  frame done; high while state==DONE
//  err        out  1  sticky stall-timeout error
//  so         out  8  debug: current state code
//  kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1
//             in   8 each  command payload sources
//  fifoc_full in   1  FIFO almost-full (asserted while >=1 slot still free)
//  fifoc_txen out  1  FIFO write enable (registered)
//  fifoc_txd  out  8  FIFO write data (registered)
// BEHAVIOUR
//  Reset: state=IDLE, fifoc_txen=0, fifoc_txd=0, err=0, snapshot regs=0, sum=0; fd=0, so=8'h00.
//  States/codes: IDLE 00, LOAD 01, HED0 02, HED1 03, CMD0..CMD8 04..0C, PART 0D, DONE 0E.
//  IDLE: fs=1 -> LOAD. LOAD: latch all 9 inputs, sum<=0 -> HED0.
//  Send states HED0..PART: at edge with full=0: txen<=1, txd<=byte, advance; with full=1: txen<=0, hold.
//  Bytes: HED0=HEAD0, HED1=HEAD1, CMD0 kind_dev, CMD1 info_sr, CMD2 cmd_filt, CMD3 cmd_mix0,
//   CMD4 cmd_reg4, CMD5 cmd_reg5, CMD6 cmd_reg6, CMD7 cmd_reg7, CMD8 cmd_mix1, PART=sum.
//  sum: 8-bit, sum<=sum+byte in each CMDn on advance; modulo 256, carry discarded; headers excluded.
//  PART -> DONE; DONE: txen<=0; stays until fs=0 -> IDLE. fd = (state==DONE).
//  Latency (no stall): fs sampled edge0; first txen high after edge2; last byte (checksum) on bus
//   after edge13 with fd=1 same cycle; 12 consecutive txen cycles; txen never high outside frame.
//  Inputs changing after LOAD do not affect the frame in flight.
//  fs dropping mid-frame: ignored; frame completes; DONE exits next edge (fd high one cycle).
//  fs held high after DONE: no retransmit until fs low then high again.
//  Reset mid-frame: immediate return to reset values; partial frame in FIFO is upstream's to flush.
//  Illegal state codes -> IDLE next edge.
// CONFIGURATION
//  FIFOC_FULL_WAIT_EN defined: fifoc_full honoured as above; stall counter counts consecutive
//   full cycles in send states, clears on advance; reaching TIMEOUT sets err (sticky until rst)
//   and FSM keeps waiting.
//  Not defined: fifoc_full ignored, frame written in 12 back-to-back cycles; err tied 0.
// TESTING
//  T1 inputs 01..09, fs=1, full=0 -> txd 55,AA,01..09,2D on 12 consecutive txen; fd after; so ends 0E.
//  T2 all inputs FF -> checksum F7 (9*FF mod 256); no carry leakage into txd.
//  T3 full=1 for 5 cycles during CMD3 -> txen low 5 cycles, no byte lost/duplicated, stream intact.
//  T4 full stuck 1 > TIMEOUT (WAIT_EN) -> err=1 at cycle TIMEOUT, stays 1 after full clears; frame finishes.
//  T5 fs held high 50 cycles -> exactly one frame, fd high until fs low, then IDLE; second fs -> second frame.
//  T6 rst pulse during CMD5 -> txen=0, so=00, fd=0 same cycle; next fs sends full fresh frame.

Source files
------------

// File: rtl/cs2fifoc.sv
// Command-frame transmitter: 55 AA, nine snapshotted payload bytes, 8-bit sum -> TX FIFO.
// Define FIFOC_FULL_WAIT_EN to honour fifoc_full with a stall-timeout error flag.
module cs2fifoc #(
    parameter logic [7:0]  HEAD0   = 8'h55,
    parameter logic [7:0]  HEAD1   = 8'hAA,
    parameter logic [15:0] TIMEOUT = 16'd1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fs,
    output logic       fd,
    output logic       err,
    output logic [7:0] so,
    input  logic [7:0] kind_dev,
    input  logic [7:0] info_sr,
    input  logic [7:0] cmd_filt,
    input  logic [7:0] cmd_mix0,
    input  logic [7:0] cmd_reg4,
    input  logic [7:0] cmd_reg5,
    input  logic [7:0] cmd_reg6,
    input  logic [7:0] cmd_reg7,
    input  logic [7:0] cmd_mix1,
    input  logic       fifoc_full,
    output logic       fifoc_txen,
    output logic [7:0] fifoc_txd
);

    typedef enum logic [3:0] {
        IDLE = 4'h0, LOAD = 4'h1, HED0 = 4'h2, HED1 = 4'h3,
        CMD0 = 4'h4, CMD1 = 4'h5, CMD2 = 4'h6, CMD3 = 4'h7,
        CMD4 = 4'h8, CMD5 = 4'h9, CMD6 = 4'hA, CMD7 = 4'hB,
        CMD8 = 4'hC, PART = 4'hD, DONE = 4'hE
    } state_e;

    state_e     state_q, state_d;
    logic       txen_q, txen_d;
    logic [7:0] txd_q, txd_d;
    logic [7:0] sum_q, sum_d;
    logic [7:0] snap_q [0:8];
    logic [7:0] snap_d [0:8];
    logic [7:0] cur_byte;
    logic       in_send;
    logic       is_cmd;
    logic       stall;

    assign in_send = (state_q >= HED0) && (state_q <= PART);
    assign is_cmd  = (state_q >= CMD0) && (state_q <= CMD8);

`ifdef FIFOC_FULL_WAIT_EN
    logic [15:0] cnt_q;
    logic        err_q;

    assign stall = fifoc_full;
    assign err   = err_q;

    // Counts consecutive stalled edges; saturates so a stuck FIFO cannot wrap it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 16'd0;
            err_q <= 1'b0;
        end else if (in_send && fifoc_full) begin
            if (cnt_q != 16'hFFFF)
                cnt_q <= cnt_q + 16'd1;
            if (({1'b0, cnt_q} + 17'd1) >= {1'b0, TIMEOUT})
                err_q <= 1'b1;
        end else begin
            cnt_q <= 16'd0;
        end
    end
`else
    logic unused_cfg;

    assign unused_cfg = fifoc_full ^ (^TIMEOUT);
    assign stall      = 1'b0;
    assign err        = 1'b0;
`endif

    always_comb begin
        cur_byte = 8'h00;
        case (state_q)
            HED0:    cur_byte = HEAD0;
            HED1:    cur_byte = HEAD1;
            CMD0:    cur_byte = snap_q[0];
            CMD1:    cur_byte = snap_q[1];
            CMD2:    cur_byte = snap_q[2];
            CMD3:    cur_byte = snap_q[3];
            CMD4:    cur_byte = snap_q[4];
            CMD5:    cur_byte = snap_q[5];
            CMD6:    cur_byte = snap_q[6];
            CMD7:    cur_byte = snap_q[7];
            CMD8:    cur_byte = snap_q[8];
            PART:    cur_byte = sum_q;
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        txen_d  = 1'b0;
        txd_d   = txd_q;
        sum_d   = sum_q;
        snap_d  = snap_q;
        case (state_q)
            IDLE: begin
                if (fs)
                    state_d = LOAD;
            end
            LOAD: begin
                snap_d  = '{kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4,
                            cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1};
                sum_d   = 8'h00;
                state_d = HED0;
            end
            DONE: begin
                if (!fs)
                    state_d = IDLE;
            end
            default: begin
                // Send states step in code order; PART+1 lands on DONE.
                if (in_send) begin
                    if (!stall) begin
                        txen_d  = 1'b1;
                        txd_d   = cur_byte;
                        state_d = state_e'(state_q + 4'd1);
                        if (is_cmd)
                            sum_d = sum_q + cur_byte;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            sum_q   <= 8'h00;
            snap_q  <= '{default: 8'h00};
        end else begin
            state_q <= state_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            sum_q   <= sum_d;
            snap_q  <= snap_d;
        end
    end

    assign fifoc_txen = txen_q;
    assign fifoc_txd  = txd_q;
    assign fd         = (state_q == DONE);
    assign so         = {4'h0, state_q};

endmodule

// File: tb/tb_cs2fifoc.sv
// Scoreboard bench for cs2fifoc: expected frame bytes queued at stimulus,
// observed txen bytes queued by a monitor, both drained and compared per test.
module tb_cs2fifoc;

    localparam logic [15:0] TO = 16'd1000;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs;
    logic       fd;
    logic       err;
    logic [7:0] so;
    logic [7:0] kind_dev, info_sr, cmd_filt, cmd_mix0, cmd_reg4;
    logic [7:0] cmd_reg5, cmd_reg6, cmd_reg7, cmd_mix1;
    logic       fifoc_full;
    logic       fifoc_txen;
    logic [7:0] fifoc_txd;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int run = 0;
    int last_run = 0;

    cs2fifoc #(.HEAD0(8'h55), .HEAD1(8'hAA), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .fs(fs), .fd(fd), .err(err), .so(so),
        .kind_dev(kind_dev), .info_sr(info_sr), .cmd_filt(cmd_filt),
        .cmd_mix0(cmd_mix0), .cmd_reg4(cmd_reg4), .cmd_reg5(cmd_reg5),
        .cmd_reg6(cmd_reg6), .cmd_reg7(cmd_reg7), .cmd_mix1(cmd_mix1),
        .fifoc_full(fifoc_full), .fifoc_txen(fifoc_txen), .fifoc_txd(fifoc_txd)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (fifoc_txen === 1'b1) begin
            obs_q.push_back(fifoc_txd);
            run = run + 1;
        end else begin
            if (run > 0) last_run = run;
            run = 0;
        end
    end

    task automatic drive_payload(input logic [71:0] p);
        kind_dev = p[7:0];   info_sr  = p[15:8];  cmd_filt = p[23:16];
        cmd_mix0 = p[31:24]; cmd_reg4 = p[39:32]; cmd_reg5 = p[47:40];
        cmd_reg6 = p[55:48]; cmd_reg7 = p[63:56]; cmd_mix1 = p[71:64];
    endtask

    task automatic push_frame(input logic [71:0] p);
        logic [7:0] s;
        s = 8'h00;
        exp_q.push_back(8'h55);
        exp_q.push_back(8'hAA);
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back(p[8*i +: 8]);
            s = s + p[8*i +: 8];
        end
        exp_q.push_back(s);
    endtask

    task automatic wait_fd(input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (fd === 1'b1) break;
        end
    endtask

    task automatic wait_so(input logic [7:0] code, input int bound);
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (so === code) break;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; fs = 1'b0; fifoc_full = 1'b0;
        drive_payload(72'h0);
        repeat (2) @(negedge clk);
        checks++; if (fifoc_txen !== 1'b0) begin errors++; $display("FAIL rst_txen got %b exp 0", fifoc_txen); end
        checks++; if (fifoc_txd !== 8'h00) begin errors++; $display("FAIL rst_txd got %h exp 00", fifoc_txd); end
        checks++; if (fd !== 1'b0) begin errors++; $display("FAIL rst_fd got %b exp 0", fd); end
        checks++; if (so !== 8'h00) begin errors++; $display("FAIL rst_so got %h exp 00", so); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        logic [71:0] p;
        logic [7:0] e, o;
        p = {8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        @(posedge clk); #1;
        push_frame(p);
        drive_payload(p);
        fs = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (so !== 8'h01) begin errors++; $display("FAIL t1_load_so got %h exp 01", so); end
        @(negedge clk);
        checks++; if (so !== 8'h02 || fifoc_txen !== 1'b0) begin errors++; $display("FAIL t1_edge1 so %h txen %b exp 02/0", so, fifoc_txen); end
        @(negedge clk);
        checks++; if (fifoc_txen !== 1'b1) begin errors++; $display("FAIL t1_first_txen got %b exp 1", fifoc_txen); end
        repeat (11) @(negedge clk);
        checks++; if (fd !== 1'b1 || so !== 8'h0E) begin errors++; $display("FAIL t1_fd_edge13 fd %b so %h exp 1/0E", fd, so); end
        checks++; if (fifoc_txd !== 8'h2D) begin errors++; $display("FAIL t1_sum_on_bus got %h exp 2D", fifoc_txd); end
        fs = 1'b0;
        @(negedge clk);
        checks++; if (so !== 8'h00 || fd !== 1'b0 || fifoc_txen !== 1'b0) begin errors++; $display("FAIL t1_idle so %h fd %b txen %b", so, fd, fifoc_txen); end
        @(negedge clk);
        checks++; if (last_run !== 12) begin errors++; $display("FAIL t1_run got %0d exp 12", last_run); end
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t1_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t1_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_allff_snapshot;
        logic [7:0] e, o;
        @(posedge clk); #1;
        push_frame({9{8'hFF}});
        drive_payload({9{8'hFF}});
        fs = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        drive_payload(72'h0);
        fs = 1'b0;
        wait_fd(40);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL t2_fd_timeout fd %b exp 1", fd); end
        checks++; if (fifoc_txd !== 8'hF7) begin errors++; $display("FAIL t2_sum got %h exp F7", fifoc_txd); end
        @(negedge clk);
        checks++; if (fd !== 1'b0 || so !== 8'h00) begin errors++; $display("FAIL t2_done_exit fd %b so %h exp 0/00", fd, so); end
        @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t2_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t2_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_full;
        logic [71:0] p;
        logic [7:0] e, o;
        int lows;
        p = {$urandom, $urandom, $urandom};
        @(posedge clk); #1;
        push_frame(p);
        drive_payload(p);
        fs = 1'b1;
`ifdef FIFOC_FULL_WAIT_EN
        wait_so(8'h07, 40);
        checks++; if (so !== 8'h07) begin errors++; $display("FAIL t3_reach_cmd3 got %h exp 07", so); end
        fifoc_full = 1'b1;
        lows = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (fifoc_txen === 1'b0) lows++;
        end
        fifoc_full = 1'b0;
        checks++; if (lows !== 5) begin errors++; $display("FAIL t3_stall_low got %0d exp 5", lows); end
        checks++; if (so !== 8'h07) begin errors++; $display("FAIL t3_hold_state got %h exp 07", so); end
`else
        fifoc_full = 1'b1;
        lows = 0;
`endif
        wait_fd(60);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL t3_fd_timeout fd %b exp 1", fd); end
`ifndef FIFOC_FULL_WAIT_EN
        checks++; if (last_run !== 12 && run !== 12) begin errors++; $display("FAIL t3_ignore_full run %0d exp 12", run); end
        repeat (int'(TO) + 10) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t3_err_tied got %b exp 0", err); end
        fifoc_full = 1'b0;
`endif
        fs = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t3_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t3_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

`ifdef FIFOC_FULL_WAIT_EN
    task automatic test_timeout;
        logic [71:0] p;
        logic [7:0] e, o;
        p = 72'h11_22_33_44_55_66_77_88_99;
        @(posedge clk); #1;
        push_frame(p);
        drive_payload(p);
        fs = 1'b1;
        wait_so(8'h03, 40);
        checks++; if (so !== 8'h03) begin errors++; $display("FAIL t4_reach_hed1 got %h exp 03", so); end
        fifoc_full = 1'b1;
        repeat (int'(TO) - 1) @(negedge clk);
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err_early got %b exp 0", err); end
        @(negedge clk);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL t4_err_set got %b exp 1", err); end
        repeat (5) @(negedge clk);
        fifoc_full = 1'b0;
        wait_fd(40);
        checks++; if (fd !== 1'b1 || err !== 1'b1) begin errors++; $display("FAIL t4_finish fd %b err %b exp 1/1", fd, err); end
        fs = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t4_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t4_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL t4_err_clear got %b exp 0", err); end
        @(negedge clk);
    endtask
`endif

    task automatic test_fs_hold;
        logic [71:0] p;
        logic [7:0] e, o;
        p = 72'hA1_B2_C3_D4_E5_F6_07_18_29;
        @(posedge clk); #1;
        push_frame(p);
        drive_payload(p);
        fs = 1'b1;
        repeat (50) @(negedge clk);
        checks++; if (fd !== 1'b1 || so !== 8'h0E) begin errors++; $display("FAIL t5_held fd %b so %h exp 1/0E", fd, so); end
        checks++; if (obs_q.size() !== 12) begin errors++; $display("FAIL t5_one_frame got %0d exp 12", obs_q.size()); end
        fs = 1'b0;
        @(negedge clk);
        checks++; if (so !== 8'h00) begin errors++; $display("FAIL t5_idle got %h exp 00", so); end
        push_frame(p);
        fs = 1'b1;
        wait_fd(40);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL t5_second_fd fd %b exp 1", fd); end
        fs = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t5_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t5_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        logic [71:0] p;
        logic [7:0] e, o;
        p = 72'h5A_4B_3C_2D_1E_0F_F0_E1_D2;
        @(posedge clk); #1;
        push_frame(p);
        drive_payload(p);
        fs = 1'b1;
        wait_so(8'h09, 40);
        checks++; if (so !== 8'h09) begin errors++; $display("FAIL t6_reach_cmd5 got %h exp 09", so); end
        #2 rst = 1'b1;
        #1;
        checks++; if (fifoc_txen !== 1'b0 || so !== 8'h00 || fd !== 1'b0) begin errors++; $display("FAIL t6_async txen %b so %h fd %b exp 0/00/0", fifoc_txen, so, fd); end
        fs = 1'b0;
        checks++; if (obs_q.size() !== 7) begin errors++; $display("FAIL t6_partial got %0d exp 7", obs_q.size()); end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_partial_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        push_frame(p);
        fs = 1'b1;
        wait_fd(40);
        checks++; if (fd !== 1'b1) begin errors++; $display("FAIL t6_fresh_fd fd %b exp 1", fd); end
        fs = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (obs_q.size() !== exp_q.size()) begin errors++; $display("FAIL t6_count got %0d exp %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front();
            checks++; if (o !== e) begin errors++; $display("FAIL t6_byte got %h exp %h", o, e); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset;
        test_basic;
        test_allff_snapshot;
        test_full;
`ifdef FIFOC_FULL_WAIT_EN
        test_timeout;
`endif
        test_fs_hold;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
